// File: rtl/pulse_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pulse_pkg
// Brief    : Shared state encoding and default widths for pulse_stretch.
// Revision : 1.0 - initial release
// ============================================================================
package pulse_pkg;

  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    COOLDOWN = 2'd2
  } state_e;

endpackage : pulse_pkg
`default_nettype wire

// File: rtl/edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : edge_detect
// Brief    : Registers an input and flags its rising edge; reset value of the
//            history register is selectable so a held-high input is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module edge_detect #(
  parameter bit PRESET = 1'b0
) (
  input  logic clock,
  input  logic resetn,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      d_q <= PRESET;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule : edge_detect
`default_nettype wire

// File: rtl/pulse_stretch.sv
`default_nettype none
// ============================================================================
// Module   : pulse_stretch
// Brief    : Stretches single-cycle events into a level of programmable length,
//            followed by an optional cooldown lockout. Define
//            PULSE_STRETCH_RETRIGGER_EN to let events during HOLD reload it.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_stretch
  import pulse_pkg::*;
#(
  parameter int CNT_W           = DEF_CNT_W,
  parameter int COOLDOWN_CYCLES = 0,
  parameter int DEF_HOLD        = 1000
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             pulse,
  input  logic             enable,
  input  logic [CNT_W-1:0] hold_len,
  output logic             level,
  output logic             busy,
  output logic             done,
  output logic             dropped,
  output logic [CNT_W-1:0] remaining
);

  if ((CNT_W < 1) || (CNT_W > 31)) begin : g_bad_cnt_w
    $error("pulse_stretch: CNT_W must be in 1..31");
  end
  if ((COOLDOWN_CYCLES < 0) ||
      (longint'(COOLDOWN_CYCLES) >= (longint'(1) << CNT_W))) begin : g_bad_cooldown
    $error("pulse_stretch: COOLDOWN_CYCLES does not fit in CNT_W bits");
  end
  if ((DEF_HOLD < 1) ||
      (longint'(DEF_HOLD) >= (longint'(1) << CNT_W))) begin : g_bad_def_hold
    $error("pulse_stretch: DEF_HOLD must be >= 1 and fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] c_def_hold = CNT_W'(DEF_HOLD);
  localparam logic [CNT_W-1:0] c_cooldown = CNT_W'(COOLDOWN_CYCLES);
  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cd_q, cd_d;
  logic             level_q, level_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dropped_q, dropped_d;

  logic             w_event;
  logic             w_reject;
  logic             w_hold_end;
  logic [CNT_W-1:0] w_len;

  // History register presets high so a pulse held through reset is not an event.
  edge_detect #(
    .PRESET (1'b1)
  ) u_edge (
    .clock  (clock),
    .resetn (resetn),
    .d_i    (pulse),
    .rise_o (w_event)
  );

  assign w_len = (hold_len == '0) ? c_def_hold : hold_len;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cd_q      <= '0;
      level_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cd_q      <= cd_d;
      level_q   <= level_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dropped_q <= dropped_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cd_d       = cd_q;
    w_reject   = 1'b0;
    w_hold_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_event) begin
          if (enable) begin
            state_d = HOLD;
            cnt_d   = w_len;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      HOLD: begin
        // cnt_q is the number of level-high cycles left including this one.
        if (cnt_q == c_one) begin
          w_hold_end = 1'b1;
          cnt_d      = '0;
          if (c_cooldown != '0) begin
            state_d = COOLDOWN;
            cd_d    = c_cooldown;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - c_one;
        end
`ifdef PULSE_STRETCH_RETRIGGER_EN
        if (w_event && enable) begin
          state_d    = HOLD;
          cnt_d      = w_len;
          cd_d       = '0;
          w_hold_end = 1'b0;
        end
        w_reject = w_event & ~enable;
`else
        w_reject = w_event;
`endif
      end
      COOLDOWN: begin
        w_reject = w_event;
        if (cd_q == c_one) begin
          state_d = IDLE;
          cd_d    = '0;
        end else begin
          cd_d = cd_q - c_one;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        cd_d    = '0;
      end
    endcase
  end

  always_comb begin
    level_d   = (state_d == HOLD);
    busy_d    = (state_d != IDLE);
    done_d    = w_hold_end;
    dropped_d = w_reject;
  end

  assign level     = level_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dropped   = dropped_q;
  assign remaining = cnt_q;

endmodule : pulse_stretch
`default_nettype wire

// File: tb/tb_pulse_stretch.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_stretch
// Brief    : Self-checking bench for pulse_stretch; expected output vectors are
//            queued per cycle as stimulus is scheduled and popped each cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_stretch;

  typedef struct packed {
    logic        level;
    logic        busy;
    logic        done;
    logic        dropped;
    logic [15:0] remaining;
  } exp_t;

  logic        clock = 1'b0;
  logic        resetn = 1'b1;
  logic        pulse = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] hold_len = 16'd0;

  logic        lvl0, busy0, done0, drop0;
  logic [15:0] rem0;
  logic        lvl1, busy1, done1, drop1;
  logic [15:0] rem1;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clock = ~clock;

  pulse_stretch #(.CNT_W(16), .COOLDOWN_CYCLES(0), .DEF_HOLD(8)) dut0 (
    .clock(clock), .resetn(resetn), .pulse(pulse), .enable(enable), .hold_len(hold_len),
    .level(lvl0), .busy(busy0), .done(done0), .dropped(drop0), .remaining(rem0)
  );

  pulse_stretch #(.CNT_W(16), .COOLDOWN_CYCLES(4), .DEF_HOLD(8)) dut1 (
    .clock(clock), .resetn(resetn), .pulse(pulse), .enable(enable), .hold_len(hold_len),
    .level(lvl1), .busy(busy1), .done(done1), .dropped(drop1), .remaining(rem1)
  );

  task automatic do_reset();
    resetn = 1'b0;
    pulse  = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e, o;
    pulse = 1'b0;
    #1 resetn = 1'b0;
    repeat (2) @(negedge clock);
    e = '0;
    sb.push_back(e);
    sb.push_back(e);
    o = {lvl0, busy0, done0, drop0, rem0};
    e = sb.pop_front();
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL reset dut0: got %h expected %h", o, e);
    end
    o = {lvl1, busy1, done1, drop1, rem1};
    e = sb.pop_front();
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL reset dut1: got %h expected %h", o, e);
    end
    resetn = 1'b1;
  endtask

  // Single event at cycle 10, hold_len 5.
  task automatic test_basic();
    exp_t e, o;
    logic [63:0] pm;
    do_reset();
    hold_len = 16'd5;
    pm = 64'd1 << 10;
    for (int c = 0; c < 20; c++) begin
      e.level     = (c >= 11 && c <= 15);
      e.busy      = e.level;
      e.done      = (c == 16);
      e.dropped   = 1'b0;
      e.remaining = e.level ? 16'(16 - c) : 16'd0;
      sb.push_back(e);
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      o = {lvl0, busy0, done0, drop0, rem0};
      e = sb.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL basic cyc %0d: got %h expected %h", c, o, e);
      end
      pulse = pm[c];
    end
  endtask

  // hold_len 0 selects DEF_HOLD; run 1 holds pulse high for 20 cycles.
  task automatic test_default_hold();
    exp_t e, o;
    logic [63:0] pm;
    for (int run = 0; run < 2; run++) begin
      do_reset();
      hold_len = 16'd0;
      pm = (run == 0) ? 64'd1 : 64'hF_FFFF;
      for (int c = 0; c < 24; c++) begin
        e.level     = (c >= 1 && c <= 8);
        e.busy      = e.level;
        e.done      = (c == 9);
        e.dropped   = 1'b0;
        e.remaining = e.level ? 16'(9 - c) : 16'd0;
        sb.push_back(e);
      end
      for (int c = 0; c < 24; c++) begin
        @(negedge clock);
        o = {lvl0, busy0, done0, drop0, rem0};
        e = sb.pop_front();
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("FAIL default_hold run %0d cyc %0d: got %h expected %h", run, c, o, e);
        end
        pulse = pm[c];
      end
    end
  endtask

  // hold_len 10, events at cycles 0 and 4.
  task automatic test_retrigger();
    exp_t e, o;
    logic [63:0] pm;
    do_reset();
    hold_len = 16'd10;
    pm = 64'h11;
    for (int c = 0; c < 18; c++) begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
      e.level     = (c >= 1 && c <= 14);
      e.done      = (c == 15);
      e.dropped   = 1'b0;
      e.remaining = !e.level ? 16'd0 : (c <= 4) ? 16'(11 - c) : 16'(15 - c);
`else
      e.level     = (c >= 1 && c <= 10);
      e.done      = (c == 11);
      e.dropped   = (c == 5);
      e.remaining = e.level ? 16'(11 - c) : 16'd0;
`endif
      e.busy = e.level;
      sb.push_back(e);
    end
    for (int c = 0; c < 18; c++) begin
      @(negedge clock);
      o = {lvl0, busy0, done0, drop0, rem0};
      e = sb.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL retrigger cyc %0d: got %h expected %h", c, o, e);
      end
      pulse = pm[c];
    end
  endtask

  // COOLDOWN_CYCLES 4, hold 3: run 0 events 0,4,7; run 1 events 0,4,8.
  task automatic test_cooldown();
    exp_t e, o;
    logic [63:0] pm;
    for (int run = 0; run < 2; run++) begin
      do_reset();
      hold_len = 16'd3;
      pm = (run == 0) ? 64'h91 : 64'h111;
      for (int c = 0; c < 18; c++) begin
        if (run == 0) begin
          e.level     = (c >= 1 && c <= 3);
          e.busy      = (c >= 1 && c <= 7);
          e.done      = (c == 4);
          e.dropped   = (c == 5 || c == 8);
          e.remaining = e.level ? 16'(4 - c) : 16'd0;
        end else begin
          e.level     = (c >= 1 && c <= 3) || (c >= 9 && c <= 11);
          e.busy      = (c >= 1 && c <= 7) || (c >= 9 && c <= 15);
          e.done      = (c == 4 || c == 12);
          e.dropped   = (c == 5);
          e.remaining = !e.level ? 16'd0 : (c <= 3) ? 16'(4 - c) : 16'(12 - c);
        end
        sb.push_back(e);
      end
      for (int c = 0; c < 18; c++) begin
        @(negedge clock);
        o = {lvl1, busy1, done1, drop1, rem1};
        e = sb.pop_front();
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("FAIL cooldown run %0d cyc %0d: got %h expected %h", run, c, o, e);
        end
        pulse = pm[c];
      end
    end
  endtask

  // Hold 3, no cooldown: run 0 event in the done cycle, run 1 event in last hold cycle.
  task automatic test_back_to_back();
    exp_t e, o;
    logic [63:0] pm;
    for (int run = 0; run < 2; run++) begin
      do_reset();
      hold_len = 16'd3;
      pm = (run == 0) ? 64'h11 : 64'h09;
      for (int c = 0; c < 12; c++) begin
        if (run == 0) begin
          e.level     = (c >= 1 && c <= 3) || (c >= 5 && c <= 7);
          e.done      = (c == 4 || c == 8);
          e.dropped   = 1'b0;
          e.remaining = !e.level ? 16'd0 : (c <= 3) ? 16'(4 - c) : 16'(8 - c);
        end else begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
          e.level     = (c >= 1 && c <= 6);
          e.done      = (c == 7);
          e.dropped   = 1'b0;
          e.remaining = !e.level ? 16'd0 : (c <= 3) ? 16'(4 - c) : 16'(7 - c);
`else
          e.level     = (c >= 1 && c <= 3);
          e.done      = (c == 4);
          e.dropped   = (c == 4);
          e.remaining = e.level ? 16'(4 - c) : 16'd0;
`endif
        end
        e.busy = e.level;
        sb.push_back(e);
      end
      for (int c = 0; c < 12; c++) begin
        @(negedge clock);
        o = {lvl0, busy0, done0, drop0, rem0};
        e = sb.pop_front();
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("FAIL back_to_back run %0d cyc %0d: got %h expected %h", run, c, o, e);
        end
        pulse = pm[c];
      end
    end
  endtask

  // Async reset at cycle 3 of a 10-cycle hold, pulse held high through release.
  task automatic test_reset_mid_hold();
    exp_t e, o;
    do_reset();
    hold_len = 16'd10;
    for (int c = 0; c < 4; c++) begin
      e.level     = (c >= 1);
      e.busy      = e.level;
      e.done      = 1'b0;
      e.dropped   = 1'b0;
      e.remaining = e.level ? 16'(11 - c) : 16'd0;
      sb.push_back(e);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      o = {lvl0, busy0, done0, drop0, rem0};
      e = sb.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset_mid_hold cyc %0d: got %h expected %h", c, o, e);
      end
      pulse = (c == 0);
    end
    #2;
    resetn = 1'b0;
    pulse  = 1'b1;
    #1;
    sb.push_back('0);
    o = {lvl0, busy0, done0, drop0, rem0};
    e = sb.pop_front();
    vectors++;
    if (o !== e) begin
      miscompares++;
      $display("FAIL reset_mid_hold async: got %h expected %h", o, e);
    end
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    for (int c = 0; c < 11; c++) sb.push_back('0);
    for (int c = 0; c < 11; c++) begin
      @(negedge clock);
      o = {lvl0, busy0, done0, drop0, rem0};
      e = sb.pop_front();
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset_release cyc %0d: got %h expected %h", c, o, e);
      end
      pulse = (c < 9);
    end
  endtask

  // Run 0: event with enable low. Run 1: enable drops mid-hold, extra event at 3.
  task automatic test_enable();
    exp_t e, o;
    logic [63:0] pm;
    for (int run = 0; run < 2; run++) begin
      do_reset();
      hold_len = 16'd5;
      pm = (run == 0) ? 64'h1 : 64'h9;
      for (int c = 0; c < 10; c++) begin
        if (run == 0) begin
          e           = '0;
          e.dropped   = (c == 1);
        end else begin
          e.level     = (c >= 1 && c <= 5);
          e.busy      = e.level;
          e.done      = (c == 6);
          e.dropped   = (c == 4);
          e.remaining = e.level ? 16'(6 - c) : 16'd0;
        end
        sb.push_back(e);
      end
      for (int c = 0; c < 10; c++) begin
        @(negedge clock);
        o = {lvl0, busy0, done0, drop0, rem0};
        e = sb.pop_front();
        vectors++;
        if (o !== e) begin
          miscompares++;
          $display("FAIL enable run %0d cyc %0d: got %h expected %h", run, c, o, e);
        end
        pulse  = pm[c];
        enable = (run == 0) ? 1'b0 : (c < 2);
      end
    end
    enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_default_hold();
    test_retrigger();
    test_cooldown();
    test_back_to_back();
    test_reset_mid_hold();
    test_enable();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, vectors %0d required completion", vectors);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_pulse_stretch
`default_nettype wire

// File: doc/pulse_stretch.md
Name: pulse_stretch

Overview:
- Inverse of the push-button edge detector: takes single-cycle event pulses and turns them into a level held for a programmable number of clock cycles.
- After the hold, a cooldown window follows in which new events are rejected.
- Sits between the button pulse logic and slow consumers: LED indicators, 7-seg blanking, and audio/tone enables.

Parameters:
- CNT_W, 16, width of the hold and cooldown counters and of the hold_len port.
- COOLDOWN_CYCLES, 0, number of level-low lockout cycles after each hold. Range 0..2^CNT_W-1.
- DEF_HOLD, 1000, hold length used when hold_len == 0.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- pulse  in  1  event input, synchronous to clock.
- enable  in  1  when 0, new events are not accepted (in-flight hold/cooldown still completes).
- hold_len  in  CNT_W  hold length in cycles; sampled only at trigger; 0 selects DEF_HOLD.
- level  out  1  stretched output.
- busy  out  1  high in HOLD or COOLDOWN.
- done  out  1  one-cycle strobe on the first cycle after a hold ends.
- dropped  out  1  one-cycle strobe when an event is rejected.
- remaining  out  CNT_W  hold cycles left including the current one; 0 outside HOLD.

Behaviour:
- Reset: resetn low asynchronously forces the following, effective immediately mid-operation:
  - state = IDLE;
  - level, busy, done and dropped = 0;
  - remaining = 0, and all counters are cleared;
  - the edge register is set to 1, so an input held high through reset does not trigger.
- Event definition: event = pulse & ~pulse_q, where pulse_q is pulse registered.
  - A level held high counts as exactly one event.
  - An event is "seen" in the cycle where it is high at the sampling edge.
- FSM states: IDLE, HOLD, COOLDOWN.
- IDLE:
  - On event & enable, latch len = (hold_len == 0) ? DEF_HOLD : hold_len, and go to HOLD.
  - On event & ~enable, dropped = 1 for the next cycle and stay in IDLE.
- Hold timing: an event sampled at the end of cycle t gives level = 1 in cycles t+1..t+len exactly.
  - remaining = len in cycle t+1 and counts down to 1 in cycle t+len.
- End of HOLD:
  - In cycle t+len+1, done = 1 and level = 0.
  - Go to COOLDOWN if COOLDOWN_CYCLES > 0, otherwise to IDLE.
- COOLDOWN lasts cycles t+len+1..t+len+COOLDOWN_CYCLES.
  - An event there is rejected, with dropped = 1 the following cycle.
  - The first cycle in which an event is accepted again is the one after the last cooldown cycle.
- Event during HOLD: rejected (dropped strobe) unless the retrigger feature is compiled in.
- Back-to-back holds with COOLDOWN_CYCLES = 0: an event in the done cycle is accepted, so level has exactly a one-cycle low gap.
- Simultaneous events:
  - done and dropped may assert in the same cycle.
  - An enable change in the trigger cycle uses the enable value sampled with the event.
- Counters:
  - Saturating-free down-counters; compare against 1 to exit. No wrap is possible because len >= 1.
  - COOLDOWN_CYCLES and DEF_HOLD are width-checked at elaboration (must be < 2^CNT_W and DEF_HOLD >= 1).
- Output timing: all outputs are registered and glitch-free.

Optional Feature:
- Macro: PULSE_STRETCH_RETRIGGER_EN.
- Defined:
  - An event during HOLD reloads the counter with a freshly sampled len.
  - level stays high continuously, and stays high for len cycles after the retrigger event.
  - done is delayed accordingly, and no dropped strobe is raised.
  - Events during COOLDOWN are still rejected.
- Undefined: events during HOLD are rejected with a dropped strobe, and the hold length is unchanged.

Decomposition:
- Shared package pulse_pkg holds:
  - the state encoding typedef (IDLE = 2'd0, HOLD = 2'd1, COOLDOWN = 2'd2);
  - DEF_CNT_W = 16.
- One natural sub-module, edge_detect: the pulse/pulse_q register pair with async active-low reset and a preset-to-1 option.

Test Plan:
1. hold_len = 5, COOLDOWN_CYCLES = 0, event at cycle 10:
   - level high in cycles 11..15;
   - remaining = 5, 4, 3, 2, 1 across those cycles;
   - done high in cycle 16;
   - busy matches level.
2. hold_len = 0, DEF_HOLD = 8: an event gives exactly 8 high cycles. Separately, pulse held high for 20 cycles gives a single 8-cycle hold and no dropped strobe.
3. hold_len = 10, event at cycle 0, second event at cycle 4:
   - macro undefined: dropped in cycle 5, level high cycles 1..10;
   - macro defined: level high cycles 1..14, done in cycle 15, no dropped strobe.
4. hold_len = 3, COOLDOWN_CYCLES = 4, event at cycle 0:
   - level high cycles 1..3;
   - busy high cycles 1..7;
   - events at cycles 4 and 7 are dropped;
   - an event at cycle 8 is accepted, giving level high cycles 9..11.
5. Reset mid-HOLD: resetn low at cycle 3 of a 10-cycle hold forces all outputs to 0 asynchronously. With pulse still high at resetn release, no trigger occurs.
6. enable = 0 with an event: dropped strobe, level stays 0. enable dropped mid-HOLD: the hold completes normally and done still fires.
